// File: rtl/bit_serializer.sv
// bit_serializer: accepts a WIDTH-bit word over valid/ready and emits it MSB-first on x, one bit per advancing clock.
// Optional build macro SERIALIZER_BACK2BACK_EN lets the next word load on the final advancing edge (zero-gap stream).
module bit_serializer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             advance,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             x_q;
    logic             x_d;
    logic             x_valid_q;
    logic             x_valid_d;

    logic [WIDTH-1:0] shifted_s;
    logic             cnt_zero_s;
    logic             word_done_s;
    logic             load_ready_s;
    logic             handshake_s;

    // Handshake decode; the back-to-back build also accepts on the final advancing edge.
    always_comb begin
        shifted_s   = shreg_q << 1;
        cnt_zero_s  = (cnt_q == CNT_ZERO);
        word_done_s = (state_q == SHIFT) && advance && cnt_zero_s;
`ifdef SERIALIZER_BACK2BACK_EN
        load_ready_s = (state_q == IDLE) || word_done_s;
`else
        load_ready_s = (state_q == IDLE);
`endif
        handshake_s = load_valid && load_ready_s;
    end

    // Next-state logic; a stalled SHIFT keeps every register so no bit is skipped or repeated.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
        case (state_q)
            IDLE: begin
                if (handshake_s) begin
                    state_d   = SHIFT;
                    shreg_d   = data_in;
                    cnt_d     = CNT_MSB;
                    x_d       = data_in[WIDTH-1];
                    x_valid_d = 1'b1;
                end else begin
                    x_d       = 1'b0;
                    x_valid_d = 1'b0;
                end
            end
            SHIFT: begin
                if (!advance) begin
                    state_d = SHIFT;
                end else if (!cnt_zero_s) begin
                    shreg_d = shifted_s;
                    cnt_d   = cnt_q - CNT_ONE;
                    x_d     = shifted_s[WIDTH-1];
                end else if (handshake_s) begin
                    // Only reachable when the final edge doubles as a load edge.
                    state_d   = SHIFT;
                    shreg_d   = data_in;
                    cnt_d     = CNT_MSB;
                    x_d       = data_in[WIDTH-1];
                    x_valid_d = 1'b1;
                end else begin
                    state_d   = IDLE;
                    shreg_d   = {WIDTH{1'b0}};
                    cnt_d     = CNT_ZERO;
                    x_d       = 1'b0;
                    x_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                shreg_d   = {WIDTH{1'b0}};
                cnt_d     = CNT_ZERO;
                x_d       = 1'b0;
                x_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; clear aborts any word in flight immediately.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            shreg_q   <= {WIDTH{1'b0}};
            cnt_q     <= CNT_ZERO;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
        end
    end

    assign load_ready = load_ready_s;
    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign last       = x_valid_q && cnt_zero_s;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH=32 main instance plus a WIDTH=1 instance).
`timescale 1ns/1ps
module tb_bit_serializer;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] data_in = 32'h0000_0000;
    logic        advance = 1'b0;
    logic        x;
    logic        x_valid;
    logic        last;
    logic        busy;

    logic        lv1 = 1'b0;
    logic        lr1;
    logic [0:0]  d1 = 1'b0;
    logic        adv1 = 1'b0;
    logic        x1;
    logic        xv1;
    logic        last1;
    logic        busy1;

    int tests_run = 0;
    int tests_failed = 0;

    bit_serializer #(.WIDTH(32), .CNT_W(5)) u_dut (
        .clk(clk), .clear(clear), .load_valid(load_valid), .load_ready(load_ready),
        .data_in(data_in), .advance(advance), .x(x), .x_valid(x_valid), .last(last), .busy(busy)
    );

    bit_serializer #(.WIDTH(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .clear(clear), .load_valid(lv1), .load_ready(lr1),
        .data_in(d1), .advance(adv1), .x(x1), .x_valid(xv1), .last(last1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        #1;
        tests_run++;
        if ({x, x_valid, busy, last, load_ready} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL reset_async: got %b expected 00001", {x, x_valid, busy, last, load_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({x, x_valid, busy, last, load_ready} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL reset_hold: got %b expected 00001", {x, x_valid, busy, last, load_ready});
        end
        tests_run++;
        if ({x1, xv1, busy1, last1, lr1} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL reset_w1: got %b expected 00001", {x1, xv1, busy1, last1, lr1});
        end
        clear = 1'b0;
        advance = 1'b1;
        step();
        tests_run++;
        if ({x_valid, busy, load_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b expected 001", {x_valid, busy, load_ready});
        end
    endtask

    task automatic test_stream();
        logic [31:0] got;
        logic [2:0]  win;
        int n, hits, lasts, last_err;
        got = 32'h0; win = 3'b000; n = 0; hits = 0; lasts = 0; last_err = 0;
        advance = 1'b1; data_in = 32'hCD4C9ACA; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 40 && !(n > 0 && !x_valid); c++) begin
            if (x_valid) begin
                got = {got[30:0], x};
                win = {win[1:0], x};
                if (n >= 2 && win == 3'b101) hits++;
                if (last) lasts++;
                if (last !== (n == 31)) last_err++;
                n++;
            end
            step();
        end
        tests_run++;
        if (got !== 32'hCD4C9ACA) begin
            tests_failed++;
            $display("FAIL stream_word: got %h expected cd4c9aca", got);
        end
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("FAIL stream_len: got %0d expected 32", n);
        end
        tests_run++;
        if (lasts != 1 || last_err != 0) begin
            tests_failed++;
            $display("FAIL stream_last: got %0d pulses %0d misplaced expected 1 pulse 0 misplaced", lasts, last_err);
        end
        tests_run++;
        if (hits != 5) begin
            tests_failed++;
            $display("FAIL stream_101_count: got %0d expected 5", hits);
        end
        tests_run++;
        if ({x, x_valid, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL stream_end_idle: got %b expected 000", {x, x_valid, busy});
        end
    endtask

    task automatic test_stall();
        logic [31:0] word;
        int n, idx, bit_err, last_err;
        word = 32'hCD4C9ACA; n = 0; bit_err = 0; last_err = 0;
        advance = 1'b1; data_in = word; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 45 && !(n > 0 && !x_valid); c++) begin
            if (x_valid) begin
                idx = (n <= 10) ? n : ((n <= 13) ? 10 : n - 3);
                if (idx > 31) bit_err++;
                else if (x !== word[5'(31 - idx)]) bit_err++;
                if (last !== (n == 34)) last_err++;
                advance = (n >= 10 && n < 13) ? 1'b0 : 1'b1;
                n++;
            end
            step();
        end
        advance = 1'b1;
        tests_run++;
        if (n != 35) begin
            tests_failed++;
            $display("FAIL stall_len: got %0d expected 35", n);
        end
        tests_run++;
        if (bit_err != 0) begin
            tests_failed++;
            $display("FAIL stall_bits: got %0d bad cycles expected 0", bit_err);
        end
        tests_run++;
        if (last_err != 0) begin
            tests_failed++;
            $display("FAIL stall_last: got %0d bad cycles expected 0", last_err);
        end
    endtask

    task automatic test_clear_mid();
        logic [31:0] got;
        int n, last_err;
        got = 32'h0; n = 0; last_err = 0;
        advance = 1'b1; data_in = 32'hCD4C9ACA; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (5) step();
        tests_run++;
        if ({x, x_valid} !== 2'b11) begin
            tests_failed++;
            $display("FAIL pre_clear_bit5: got %b expected 11", {x, x_valid});
        end
        #2;
        clear = 1'b1;
        #1;
        tests_run++;
        if ({x, x_valid, busy, last, load_ready} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL clear_async: got %b expected 00001", {x, x_valid, busy, last, load_ready});
        end
        step();
        clear = 1'b0;
        step();
        tests_run++;
        if ({x, x_valid, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL clear_no_partial: got %b expected 000", {x, x_valid, busy});
        end
        data_in = 32'h80000001; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 40 && !(n > 0 && !x_valid); c++) begin
            if (x_valid) begin
                got = {got[30:0], x};
                if (last !== (n == 31)) last_err++;
                n++;
            end
            step();
        end
        tests_run++;
        if (got !== 32'h80000001 || n != 32) begin
            tests_failed++;
            $display("FAIL clear_next_word: got %h/%0d bits expected 80000001/32 bits", got, n);
        end
        tests_run++;
        if (last_err != 0) begin
            tests_failed++;
            $display("FAIL clear_next_last: got %0d bad cycles expected 0", last_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa;
        logic [31:0] wb;
        logic        exp_v, exp_x, exp_last, hs, gap_v;
        int accepted, errs, b_start, v_cnt;
        wa = 32'hA5A5A5A5; wb = 32'h0000FFFF; accepted = 0; errs = 0; v_cnt = 0; gap_v = 1'b0;
`ifdef SERIALIZER_BACK2BACK_EN
        b_start = 33;
`else
        b_start = 34;
`endif
        advance = 1'b1; data_in = wa; load_valid = 1'b1;
        for (int k = 0; k < 72; k++) begin
            exp_v = 1'b0; exp_x = 1'b0; exp_last = 1'b0;
            if (k >= 1 && k <= 32) begin
                exp_v = 1'b1; exp_x = wa[5'(32 - k)]; exp_last = (k == 32);
            end else if (k >= b_start && k < b_start + 32) begin
                exp_v = 1'b1; exp_x = wb[5'(31 - (k - b_start))]; exp_last = (k == b_start + 31);
            end
            if ({x_valid, x, last} !== {exp_v, exp_x, exp_last}) errs++;
            if (x_valid) v_cnt++;
            if (k == 33) gap_v = x_valid;
            hs = load_valid && load_ready;
            step();
            if (hs) begin
                accepted++;
                if (accepted == 1) data_in = wb;
                else load_valid = 1'b0;
            end
        end
        load_valid = 1'b0;
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL b2b_stream: got %0d bad cycles expected 0", errs);
        end
        tests_run++;
        if (v_cnt != 64 || accepted != 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d valid %0d words expected 64 valid 2 words", v_cnt, accepted);
        end
        tests_run++;
`ifdef SERIALIZER_BACK2BACK_EN
        if (gap_v !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap: got x_valid=%b expected 1", gap_v);
        end
`else
        if (gap_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: got x_valid=%b expected 0", gap_v);
        end
`endif
    endtask

    task automatic test_hold_data();
        logic [31:0] got;
        logic        hs;
        int n, ones;
        got = 32'h0; n = 0; ones = 0;
        advance = 1'b1; data_in = 32'h3C0F00A5; load_valid = 1'b1;
        step();
        data_in = 32'hFFFFFFFF;
        for (int c = 0; c < 40 && n < 32; c++) begin
            if (x_valid) begin
                got = {got[30:0], x};
                n++;
            end
            hs = load_valid && load_ready;
            step();
            if (hs) load_valid = 1'b0;
        end
        tests_run++;
        if (got !== 32'h3C0F00A5 || n != 32) begin
            tests_failed++;
            $display("FAIL hold_word: got %h/%0d bits expected 3c0f00a5/32 bits", got, n);
        end
`ifndef SERIALIZER_BACK2BACK_EN
        tests_run++;
        if ({x_valid, x, load_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL hold_idle_gap: got %b expected 001", {x_valid, x, load_ready});
        end
        step();
        load_valid = 1'b0;
`endif
        tests_run++;
        if ({x_valid, x} !== 2'b11) begin
            tests_failed++;
            $display("FAIL hold_next_start: got %b expected 11", {x_valid, x});
        end
        for (int c = 0; c < 40 && x_valid; c++) begin
            if (x) ones++;
            step();
        end
        tests_run++;
        if (x_valid !== 1'b0 || ones != 32) begin
            tests_failed++;
            $display("FAIL hold_next_drain: got x_valid=%b ones=%0d expected 0/32", x_valid, ones);
        end
    endtask

    task automatic test_width1();
        lv1 = 1'b1; d1 = 1'b1; adv1 = 1'b1;
        step();
        lv1 = 1'b0;
        tests_run++;
        if ({x1, xv1, last1, busy1} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL w1_first_bit: got %b expected 1111", {x1, xv1, last1, busy1});
        end
        step();
        tests_run++;
        if ({x1, xv1, last1, busy1, lr1} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL w1_done: got %b expected 00001", {x1, xv1, last1, busy1, lr1});
        end
        lv1 = 1'b1; adv1 = 1'b0;
        step();
        lv1 = 1'b0;
        step();
        tests_run++;
        if ({x1, xv1, last1, busy1} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL w1_stall: got %b expected 1111", {x1, xv1, last1, busy1});
        end
        adv1 = 1'b1;
        step();
        tests_run++;
        if ({x1, xv1, last1, busy1} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL w1_stall_done: got %b expected 0000", {x1, xv1, last1, busy1});
        end
        adv1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_clear_mid();
        test_back_to_back();
        test_hold_data();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
